fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of the 16-bit, 8-entry transfer buffer among several producers. It sits in the write-clock domain directly in front of the buffer's `data_1` / `data_1_en` inputs. It grants one requester at a time for a bounded burst and never issues a write while the buffer reports full. It also exports the current owner and a running word count for debug.

---
 rtl/fifo_write_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin owner of the transfer buffer write port.
// Grants bounded bursts, holds off while the buffer is full.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk_1,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    buf_full,
  output logic [DATA_W-1:0]       buf_data,
  output logic                    buf_en,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic [15:0]             word_total
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);
  localparam logic [2:0] RST_LAST  = 3'(N_REQ - 1);

  state_t      state, state_d;
  logic [2:0]  owner, owner_d;
  logic [2:0]  last_grant, last_d;
  logic [2:0]  pick;
  logic [3:0]  beat_cnt, beat_d;
  logic [15:0] total_d;
  logic        found;
  int          idx;

  logic [N_REQ-1:0]  own_oh;
  logic              own_valid;
  logic              xfer;
  logic [DATA_W-1:0] own_data;

  // Search starts just past the previous owner.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!found && |(req_valid & (N_REQ'(1) << idx))) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == 3'(i))
        own_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign own_oh    = N_REQ'(1) << owner;
  assign own_valid = |(req_valid & own_oh);
  assign xfer      = own_valid & ~buf_full;

  always_comb begin
    state_d   = state;
    owner_d   = owner;
    last_d    = last_grant;
    beat_d    = beat_cnt;
    total_d   = word_total;
    req_ready = '0;
    buf_en    = 1'b0;
    busy      = 1'b0;
    grant_id  = last_grant;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          owner_d = pick;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        busy      = 1'b1;
        grant_id  = owner;
        req_ready = buf_full ? '0 : own_oh;
        buf_en    = xfer;
        if (xfer) begin
          beat_d  = beat_cnt + 4'd1;
          total_d = word_total + 16'd1;
        end
        // A dropped valid ends the burst even during a full stall.
        if (!own_valid || (xfer && beat_cnt == LAST_BEAT)) begin
          state_d = IDLE;
          last_d  = owner;
        end
      end
    endcase
  end

  assign buf_data = buf_en ? own_data : '0;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= RST_LAST;
      beat_cnt   <= '0;
      word_total <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_grant <= last_d;
      beat_cnt   <= beat_d;
      word_total <= total_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scoreboard bench with a round-robin reference model.
// Lane words carry lane and sequence number so loss or duplication shows up.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic           clk_1 = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           buf_full = 1'b0;
  logic [W-1:0]   buf_data;
  logic           buf_en;
  logic [2:0]     grant_id;
  logic           busy;
  logic [15:0]    word_total;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        got;
  logic [2:0] gl[$];
  logic       prev_busy = 1'b0;

  bit m_busy;
  int m_owner, m_last, m_beats, m_total;
  int seq[N];

  fifo_write_arbiter #(
    .N_REQ(N), .DATA_W(W), .MAX_BURST(MB)
  ) dut (
    .clk_1(clk_1), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .buf_full(buf_full),
    .buf_data(buf_data), .buf_en(buf_en),
    .grant_id(grant_id), .busy(busy),
    .word_total(word_total)
  );

  always #5 clk_1 = ~clk_1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] word(input int i);
    return {4'(8 + i), 12'(seq[i])};
  endfunction

  // Monitor: every strobe must match the next predicted write.
  always @(negedge clk_1) begin
    if (!rst) begin
      if (buf_en) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_write: data %0h id %0d",
                   buf_data, grant_id);
        end else begin
          got = exp_q.pop_front();
          chk("wr_data", 32'(buf_data), 32'(got.data));
          chk("wr_id", 32'(grant_id), 32'(got.id));
        end
      end else begin
        chk("idle_data", 32'(buf_data), 0);
        chk("pending_writes", exp_q.size(), 0);
        exp_q.delete();
      end
    end
  end

  // Reference: round-robin from last owner, up to MB words per grant.
  task automatic model_eval();
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c = (m_last + k) % N;
        if (req_valid[c]) begin
          m_owner = c;
          m_busy  = 1'b1;
          m_beats = 0;
          break;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_last = m_owner;
      m_busy = 1'b0;
    end else if (!buf_full) begin
      exp_q.push_back('{id: 3'(m_owner), data: word(m_owner)});
      seq[m_owner]++;
      m_total++;
      m_beats++;
      if (m_beats == MB) begin
        m_last = m_owner;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic full);
    logic [N-1:0] e_rdy;
    logic [2:0]   e_gid;
    logic         e_busy;
    logic [15:0]  e_tot;
    @(posedge clk_1);
    #1;
    req_valid = v;
    buf_full  = full;
    for (int i = 0; i < N; i++)
      req_data[i*W +: W] = word(i);
    e_busy = m_busy;
    e_gid  = 3'(m_busy ? m_owner : m_last);
    e_rdy  = (m_busy && !full) ? (N'(1) << m_owner) : '0;
    e_tot  = 16'(m_total);
    model_eval();
    @(negedge clk_1);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("grant_id", 32'(grant_id), 32'(e_gid));
    chk("word_total", 32'(word_total), 32'(e_tot));
    if (busy && !prev_busy)
      gl.push_back(grant_id);
    prev_busy = busy;
  endtask

  task automatic hit_reset(input bit mid_burst);
    @(posedge clk_1);
    #2;
    if (mid_burst) begin
      chk("pre_rst_busy", 32'(busy), 1);
      chk("pre_rst_en", 32'(buf_en), 1);
    end
    #1;
    rst = 1'b1;
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_beats = 0;
    m_total = 0;
    prev_busy = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_en", 32'(buf_en), 0);
    chk("rst_data", 32'(buf_data), 0);
    chk("rst_gid", 32'(grant_id), 3);
    chk("rst_total", 32'(word_total), 0);
    exp_q.delete();
    req_valid = '0;
    buf_full  = 1'b0;
    @(posedge clk_1);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) seq[i] = 0;

    hit_reset(1'b0);

    // Requester 2 alone: four words then an idle cycle.
    for (int c = 0; c < 5; c++) step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    chk("t1_total", 32'(word_total), 4);
    chk("t1_gid", 32'(grant_id), 2);

    // All valid: rotation 0,1,2,3.
    hit_reset(1'b0);
    gl.delete();
    for (int c = 0; c < 20; c++) step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);
    chk("t2_total", 32'(word_total), 16);
    chk("t2_grants", gl.size(), 4);
    for (int i = 0; i < 4 && i < gl.size(); i++)
      chk("t2_order", 32'(gl[i]), i);

    // Full stall after the 2nd word of requester 1.
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(4'b0010, 1'b1);
      chk("t3_stall_rdy", 32'(req_ready), 0);
      chk("t3_stall_en", 32'(buf_en), 0);
    end
    step(4'b0010, 1'b0);
    chk("t3_resume_en", 32'(buf_en), 1);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    chk("t3_total", 32'(word_total), 20);

    // Requester 3 abandons after two words; 0 is next.
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b0001, 1'b0);
    chk("t4_drop_en", 32'(buf_en), 0);
    step(4'b0001, 1'b0);
    chk("t4_last", 32'(grant_id), 3);
    chk("t4_idle", 32'(busy), 0);
    step(4'b0001, 1'b0);
    chk("t4_next", 32'(grant_id), 0);
    step(4'b0000, 1'b0);

    // Reset while requester 2 is writing.
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    hit_reset(1'b1);
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    chk("t5_regrant", 32'(grant_id), 1);
    step(4'b0000, 1'b0);

    // Random traffic, including drops during full stalls.
    v = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0)
        v = N'($urandom_range(0, 15));
      step(v, $urandom_range(0, 3) == 0);
    end
    step(4'b0000, 1'b0);

    // Word counter wrap: 65537 writes read back as 1.
    hit_reset(1'b0);
    for (int c = 0; c < 90000 && m_total < 65537; c++)
      step(4'b1111, 1'b0);
    chk("t7_budget", m_total, 65537);
    step(4'b0000, 1'b0);
    chk("t7_wrap", 32'(word_total), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
